mtt_wr_engine_v2: RTL

- Parametrised successor to the CEU MTT write thread in ICMMgt/MRMgt.
- Takes one CEU MTT-write command: a head plus N data beats, each beat packing ENTRIES_PER_BEAT MTT entries.
- For every entry it performs an ICM address translation, then issues a cache-set request to the MTT ICM cache.
- Beyond the earlier thread, it adds: generic beat and entry widths, zero-length and out-of-range handling, req_last consistency checking, and optional translation reuse within an ICM page.

---
 rtl/mtt_wr_engine_v2.sv | 204 ++++++++++++++++++++
 1 files changed

// File: rtl/mtt_wr_engine_v2.sv
// CEU MTT write engine: one ICM translation and one cache-set request per entry.
// Optional macro MTT_WR_MAP_REUSE_EN reuses a translation for entries in the same ICM page.
module mtt_wr_engine_v2 #(
    parameter int HEAD_WIDTH     = 128,
    parameter int DATA_WIDTH     = 256,
    parameter int ENTRY_WIDTH    = 64,
    parameter int ENTRY_NUM      = 2**20,
    parameter int ICM_ADDR_WIDTH = 64,
    parameter int PHY_ADDR_WIDTH = 64,
    parameter int PAGE_ENTRY_LOG = 9,
    localparam int EPB           = DATA_WIDTH / ENTRY_WIDTH,
    localparam int INDEX_WIDTH   = $clog2(ENTRY_NUM),
    localparam int SET_HEAD_W    = 10 + ICM_ADDR_WIDTH + PHY_ADDR_WIDTH
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      mtt_req_valid,
    input  logic [HEAD_WIDTH-1:0]     mtt_req_head,
    input  logic                      mtt_req_last,
    input  logic [DATA_WIDTH-1:0]     mtt_req_data,
    output logic                      mtt_req_ready,
    output logic                      cache_set_req_valid,
    output logic [SET_HEAD_W-1:0]     cache_set_req_head,
    output logic [ENTRY_WIDTH-1:0]    cache_set_req_data,
    input  logic                      cache_set_req_ready,
    output logic                      icm_mapping_lookup_valid,
    output logic [INDEX_WIDTH-1:0]    icm_mapping_lookup_head,
    input  logic                      icm_mapping_lookup_ready,
    input  logic                      icm_mapping_rsp_valid,
    input  logic [ICM_ADDR_WIDTH-1:0] icm_mapping_rsp_icm_addr,
    input  logic [PHY_ADDR_WIDTH-1:0] icm_mapping_rsp_phy_addr,
    output logic                      icm_mapping_rsp_ready,
    output logic                      err_valid,
    output logic                      busy
);

    localparam int SLOT_W = (EPB > 1) ? $clog2(EPB) : 1;
    localparam logic [65:0] ENTRY_NUM_EXT = 66'(ENTRY_NUM);
    localparam logic [ICM_ADDR_WIDTH-1:0] ICM_STEP = ICM_ADDR_WIDTH'(ENTRY_WIDTH / 8);
    localparam logic [PHY_ADDR_WIDTH-1:0] PHY_STEP = PHY_ADDR_WIDTH'(ENTRY_WIDTH / 8);

    if (EPB < 1 || (EPB & (EPB - 1)) != 0 || PAGE_ENTRY_LOG < 0 ||
        PAGE_ENTRY_LOG >= INDEX_WIDTH) begin : g_bad_cfg
        $error("mtt_wr_engine_v2: illegal entry/page geometry");
    end

    typedef enum logic [2:0] {
        IDLE,
        ADDR_REQ,
        ADDR_RSP,
        CACHE_SET,
        DRAIN
    } state_t;

    state_t                    state, state_nxt;
    logic [31:0]               num_q, num_d;
    logic [31:0]               cnt_q, cnt_d;
    logic [63:0]               start_q, start_d;
    logic [ICM_ADDR_WIDTH-1:0] icm_q, icm_d;
    logic [PHY_ADDR_WIDTH-1:0] phy_q, phy_d;
    logic                      err_q, err_d;

    logic [31:0]               hd_num;
    logic [63:0]               hd_start;
    logic [65:0]               hd_end;
    logic [63:0]               cur_idx;
    logic [31:0]               cnt_inc;
    logic [SLOT_W-1:0]         slot;
    logic [ENTRY_WIDTH-1:0]    slot_data;
    logic                      slot_last;
    logic                      last_entry;
    logic                      set_hs;
    logic                      unused_head;

    assign hd_num      = mtt_req_head[95:64];
    assign hd_start    = mtt_req_head[63:0];
    assign hd_end      = {2'b00, hd_start} + {34'd0, hd_num};
    assign unused_head = ^mtt_req_head[HEAD_WIDTH-1:96];

    assign cur_idx    = start_q + {32'd0, cnt_q};
    assign cnt_inc    = cnt_q + 32'd1;
    assign last_entry = (cnt_inc == num_q);

    if (EPB > 1) begin : g_slot
        assign slot = cnt_q[SLOT_W-1:0];
    end else begin : g_slot_one
        assign slot = '0;
    end

    assign slot_last = (slot == SLOT_W'(EPB - 1));
    assign slot_data = mtt_req_data[slot*ENTRY_WIDTH +: ENTRY_WIDTH];
    assign set_hs    = (state == CACHE_SET) && mtt_req_valid && cache_set_req_ready;

`ifdef MTT_WR_MAP_REUSE_EN
    logic [63:0] nxt_idx;
    logic        same_page;

    assign nxt_idx   = cur_idx + 64'd1;
    assign same_page = (cur_idx >> PAGE_ENTRY_LOG) == (nxt_idx >> PAGE_ENTRY_LOG);
`endif

    assign icm_mapping_lookup_head = cur_idx[INDEX_WIDTH-1:0];
    assign cache_set_req_head      = {10'd0, phy_q, icm_q};
    assign err_valid               = err_q;
    assign busy                    = (state != IDLE);

    always_comb begin
        state_nxt                = state;
        num_d                    = num_q;
        start_d                  = start_q;
        cnt_d                    = cnt_q;
        icm_d                    = icm_q;
        phy_d                    = phy_q;
        err_d                    = 1'b0;
        mtt_req_ready            = 1'b0;
        cache_set_req_valid      = 1'b0;
        cache_set_req_data       = '0;
        icm_mapping_lookup_valid = 1'b0;
        icm_mapping_rsp_ready    = 1'b0;
        unique case (state)
            IDLE: begin
                if (mtt_req_valid) begin
                    num_d   = hd_num;
                    start_d = hd_start;
                    cnt_d   = '0;
                    if (hd_num == 32'd0) begin
                        state_nxt = DRAIN;
                    end else if (hd_end > ENTRY_NUM_EXT) begin
                        state_nxt = DRAIN;
                        err_d     = 1'b1;
                    end else begin
                        state_nxt = ADDR_REQ;
                    end
                end
            end
            ADDR_REQ: begin
                icm_mapping_lookup_valid = 1'b1;
                if (icm_mapping_lookup_ready) state_nxt = ADDR_RSP;
            end
            ADDR_RSP: begin
                icm_mapping_rsp_ready = 1'b1;
                if (icm_mapping_rsp_valid) begin
                    icm_d     = icm_mapping_rsp_icm_addr;
                    phy_d     = icm_mapping_rsp_phy_addr;
                    state_nxt = CACHE_SET;
                end
            end
            CACHE_SET: begin
                // A beat that has not arrived yet simply holds the request low.
                cache_set_req_valid = mtt_req_valid;
                cache_set_req_data  = slot_data;
                if (set_hs) begin
                    cnt_d         = cnt_inc;
                    mtt_req_ready = slot_last || last_entry;
                    if (last_entry) begin
                        state_nxt = mtt_req_last ? IDLE : DRAIN;
                        err_d     = !mtt_req_last;
                    end else if (slot_last && mtt_req_last) begin
                        state_nxt = IDLE;
                        err_d     = 1'b1;
                    end else begin
`ifdef MTT_WR_MAP_REUSE_EN
                        if (same_page) begin
                            icm_d     = icm_q + ICM_STEP;
                            phy_d     = phy_q + PHY_STEP;
                            state_nxt = CACHE_SET;
                        end else begin
                            state_nxt = ADDR_REQ;
                        end
`else
                        state_nxt = ADDR_REQ;
`endif
                    end
                end
            end
            DRAIN: begin
                mtt_req_ready = mtt_req_valid;
                if (mtt_req_valid && mtt_req_last) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            num_q   <= '0;
            cnt_q   <= '0;
            start_q <= '0;
            icm_q   <= '0;
            phy_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state   <= state_nxt;
            num_q   <= num_d;
            cnt_q   <= cnt_d;
            start_q <= start_d;
            icm_q   <= icm_d;
            phy_q   <= phy_d;
            err_q   <= err_d;
        end
    end

endmodule
